// File: rtl/trap_if.sv
// Core <-> trap sequencer bundle: trap/mret/irq requests, the shared CSR port
// and the fetch redirect.
interface trap_if #(parameter int XLEN = 64);
  logic            trap_req;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic            mret_req;
  logic            irq_pending;
  logic            irq_en;
  logic            irq_window;
  logic [XLEN-1:0] irq_pc;
  logic            busy;
  logic [11:0]     csr_idx;
  logic            csr_ren;
  logic            csr_wen;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport slave (
    input  trap_req, trap_cause, trap_pc, mret_req,
    input  irq_pending, irq_en, irq_window, irq_pc, csr_rdata,
    output busy, csr_idx, csr_ren, csr_wen, csr_wdata,
    output redirect_valid, redirect_pc
  );

  modport master (
    output trap_req, trap_cause, trap_pc, mret_req,
    output irq_pending, irq_en, irq_window, irq_pc, csr_rdata,
    input  busy, csr_idx, csr_ren, csr_wen, csr_wdata,
    input  redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: drives trap entry / mret as a string of single
// CSR accesses on the shared port, then pulses a fetch redirect.
module trap_ctrl #(
  parameter int XLEN = 64
) (
  input logic   clk,
  input logic   rst,
  trap_if.slave bus
);
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] T_WEPC   = 4'd1;
  localparam logic [3:0] T_WCAUSE = 4'd2;
  localparam logic [3:0] T_RSTAT  = 4'd3;
  localparam logic [3:0] T_WSTAT  = 4'd4;
  localparam logic [3:0] T_RVEC   = 4'd5;
  localparam logic [3:0] M_RSTAT  = 4'd6;
  localparam logic [3:0] M_WSTAT  = 4'd7;
  localparam logic [3:0] M_REPC   = 4'd8;
  localparam logic [3:0] REDIR    = 4'd9;

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, {(XLEN-4){1'b0}}, 3'd7};

  logic [3:0]      state;
  logic [XLEN-1:0] pc, cause, shadow, target;
  logic            is_irq;

  logic            irq_take;
  logic [XLEN-1:0] base, vec_tgt, trap_stat, mret_stat;

  assign irq_take = bus.irq_pending & bus.irq_en & bus.irq_window;
  assign base     = {bus.csr_rdata[XLEN-1:2], 2'b00};
  // cause << 2 with the interrupt flag dropped; the add wraps at XLEN bits
  assign vec_tgt  = base + {cause[XLEN-3:0], 2'b00};

  always_comb begin
    trap_stat        = shadow;
    trap_stat[7]     = shadow[3];
    trap_stat[3]     = 1'b0;
    trap_stat[12:11] = 2'b11;
    mret_stat        = shadow;
    mret_stat[3]     = shadow[7];
    mret_stat[7]     = 1'b1;
    mret_stat[12:11] = 2'b11;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pc     <= '0;
      cause  <= '0;
      shadow <= '0;
      target <= '0;
      is_irq <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.trap_req) begin
            pc     <= bus.trap_pc;
            cause  <= bus.trap_cause;
            is_irq <= 1'b0;
            state  <= T_WEPC;
          end else if (bus.mret_req) begin
            state  <= M_RSTAT;
          end else if (irq_take) begin
            pc     <= bus.irq_pc;
            cause  <= IRQ_CAUSE;
            is_irq <= 1'b1;
            state  <= T_WEPC;
          end
        end
        T_WEPC:   state <= T_WCAUSE;
        T_WCAUSE: state <= T_RSTAT;
        T_RSTAT: begin
          shadow <= bus.csr_rdata;
          state  <= T_WSTAT;
        end
        T_WSTAT:  state <= T_RVEC;
        T_RVEC: begin
          // only vectored mode (1) on an interrupt offsets; modes 2/3 act direct
          target <= (bus.csr_rdata[1:0] == 2'b01 && is_irq) ? vec_tgt : base;
          state  <= REDIR;
        end
        M_RSTAT: begin
          shadow <= bus.csr_rdata;
          state  <= M_WSTAT;
        end
        M_WSTAT:  state <= M_REPC;
        M_REPC: begin
          target <= {bus.csr_rdata[XLEN-1:1], 1'b0};
          state  <= REDIR;
        end
        REDIR: begin
          is_irq <= 1'b0;
          state  <= IDLE;
        end
        default:  state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy           = (state != IDLE);
    bus.csr_idx        = '0;
    bus.csr_ren        = 1'b0;
    bus.csr_wen        = 1'b0;
    bus.csr_wdata      = '0;
    bus.redirect_valid = (state == REDIR);
    bus.redirect_pc    = (state == REDIR) ? target : '0;
    case (state)
      T_WEPC:   begin bus.csr_wen = 1'b1; bus.csr_idx = MEPC;    bus.csr_wdata = pc;        end
      T_WCAUSE: begin bus.csr_wen = 1'b1; bus.csr_idx = MCAUSE;  bus.csr_wdata = cause;     end
      T_RSTAT:  begin bus.csr_ren = 1'b1; bus.csr_idx = MSTATUS;                            end
      T_WSTAT:  begin bus.csr_wen = 1'b1; bus.csr_idx = MSTATUS; bus.csr_wdata = trap_stat; end
      T_RVEC:   begin bus.csr_ren = 1'b1; bus.csr_idx = MTVEC;                              end
      M_RSTAT:  begin bus.csr_ren = 1'b1; bus.csr_idx = MSTATUS;                            end
      M_WSTAT:  begin bus.csr_wen = 1'b1; bus.csr_idx = MSTATUS; bus.csr_wdata = mret_stat; end
      M_REPC:   begin bus.csr_ren = 1'b1; bus.csr_idx = MEPC;                               end
      default:  ;
    endcase
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized bench for trap_ctrl: small CSR file on the port, spec-level
// model of each sequence's CSR traffic, final CSR state and redirect.
module tb_trap_ctrl;
  logic clk, rst;
  trap_if #(.XLEN(64)) bus ();

  trap_ctrl #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file seen by the DUT; load lets the bench preset it
  logic [63:0] csr_ms, csr_tv, csr_epc, csr_cause;
  logic [63:0] ld_ms, ld_tv, ld_epc, ld_cause;
  logic        load;

  always_comb begin
    bus.csr_rdata = '0;
    case (bus.csr_idx)
      12'h300: bus.csr_rdata = csr_ms;
      12'h305: bus.csr_rdata = csr_tv;
      12'h341: bus.csr_rdata = csr_epc;
      12'h342: bus.csr_rdata = csr_cause;
      default: bus.csr_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (load) begin
      csr_ms <= ld_ms; csr_tv <= ld_tv; csr_epc <= ld_epc; csr_cause <= ld_cause;
    end else if (bus.csr_wen) begin
      case (bus.csr_idx)
        12'h300: csr_ms    <= bus.csr_wdata;
        12'h305: csr_tv    <= bus.csr_wdata;
        12'h341: csr_epc   <= bus.csr_wdata;
        12'h342: csr_cause <= bus.csr_wdata;
        default: ;
      endcase
    end
  end

  // reference architectural state
  logic [63:0] m_ms, m_tv, m_epc, m_cause, last_rpc;
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] f_trap_ms(input logic [63:0] s);
    return (s & ~64'h1888) | 64'h1800 | (((s >> 3) & 64'd1) << 7);
  endfunction

  function automatic logic [63:0] f_mret_ms(input logic [63:0] s);
    return (s & ~64'h1888) | 64'h1880 | (((s >> 7) & 64'd1) << 3);
  endfunction

  function automatic logic [63:0] f_vec(input logic [63:0] tv, input bit irq, input logic [63:0] c);
    logic [63:0] mode, b;
    mode = tv % 4;
    b    = tv - mode;
    if (mode == 1 && irq) return b + 4 * (c & 64'h7FFF_FFFF_FFFF_FFFF);
    return b;
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic clear_reqs();
    bus.trap_req = 1'b0; bus.mret_req = 1'b0;
    bus.irq_pending = 1'b0; bus.irq_en = 1'b0; bus.irq_window = 1'b0;
  endtask

  task automatic setup(input logic [63:0] ms, input logic [63:0] tv, input logic [63:0] epc);
    ld_ms = ms; ld_tv = tv; ld_epc = epc; ld_cause = m_cause;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    m_ms = ms; m_tv = tv; m_epc = epc;
  endtask

  // kind: 0 trap_req, 1 mret_req, 2 timer interrupt
  task automatic run_seq(input int kind, input logic [63:0] cause, input logic [63:0] pc,
                         input bit all_req, input bit noise);
    int L;
    logic [63:0] ecause, tgt, new_ms;
    logic [9:0]  e_wen, e_ren;
    logic [11:0] e_idx [10];
    logic [63:0] e_wd  [10];
    e_wen = '0; e_ren = '0; ecause = cause;
    for (int k = 0; k < 10; k++) begin e_idx[k] = '0; e_wd[k] = '0; end
    if (kind == 1) begin
      L = 4; new_ms = f_mret_ms(m_ms); tgt = m_epc & ~64'd1;
      e_ren[1] = 1'b1; e_idx[1] = 12'h300;
      e_wen[2] = 1'b1; e_idx[2] = 12'h300; e_wd[2] = new_ms;
      e_ren[3] = 1'b1; e_idx[3] = 12'h341;
    end else begin
      L = 6;
      if (kind == 2) ecause = 64'h8000_0000_0000_0007;
      new_ms = f_trap_ms(m_ms); tgt = f_vec(m_tv, kind == 2, ecause);
      e_wen[1] = 1'b1; e_idx[1] = 12'h341; e_wd[1] = pc;
      e_wen[2] = 1'b1; e_idx[2] = 12'h342; e_wd[2] = ecause;
      e_ren[3] = 1'b1; e_idx[3] = 12'h300;
      e_wen[4] = 1'b1; e_idx[4] = 12'h300; e_wd[4] = new_ms;
      e_ren[5] = 1'b1; e_idx[5] = 12'h305;
    end
    case (kind)
      0: begin
        bus.trap_req = 1'b1; bus.trap_cause = cause; bus.trap_pc = pc;
        if (all_req) begin
          bus.mret_req = 1'b1; bus.irq_pending = 1'b1; bus.irq_en = 1'b1;
          bus.irq_window = 1'b1; bus.irq_pc = ~pc;
        end
      end
      1: bus.mret_req = 1'b1;
      default: begin
        bus.irq_pending = 1'b1; bus.irq_en = 1'b1; bus.irq_window = 1'b1;
        bus.irq_pc = pc; bus.trap_cause = r64();
      end
    endcase
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      chk("busy",  64'(bus.busy),    64'(k <= L));
      chk("wen",   64'(bus.csr_wen), 64'(e_wen[k]));
      chk("ren",   64'(bus.csr_ren), 64'(e_ren[k]));
      chk("idx",   64'(bus.csr_idx), 64'(e_idx[k]));
      if (e_wen[k] || !e_ren[k]) chk("wdata", bus.csr_wdata, e_wd[k]);
      chk("rvalid", 64'(bus.redirect_valid), 64'(k == L));
      chk("rpc",    bus.redirect_pc, (k == L) ? tgt : 64'd0);
      if (bus.redirect_valid) last_rpc = bus.redirect_pc;
      if (k == 1) clear_reqs();
      if (noise && k == 2) begin bus.mret_req = 1'b1; bus.trap_req = 1'b1; end
      if (noise && k == 3) clear_reqs();
    end
    m_ms = new_ms;
    if (kind != 1) begin m_epc = pc; m_cause = ecause; end
    chk("mstatus", csr_ms, m_ms);
    chk("mepc",    csr_epc, m_epc);
    chk("mcause",  csr_cause, m_cause);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_ren"},  64'(bus.csr_ren), 64'd0);
    chk({tag, "_wen"},  64'(bus.csr_wen), 64'd0);
    chk({tag, "_idx"},  64'(bus.csr_idx), 64'd0);
    chk({tag, "_wd"},   bus.csr_wdata, 64'd0);
    chk({tag, "_rv"},   64'(bus.redirect_valid), 64'd0);
    chk({tag, "_rpc"},  bus.redirect_pc, 64'd0);
  endtask

  initial begin
    logic [63:0] pc0, c0;
    int kind;
    load = 1'b0; m_cause = '0; last_rpc = '0;
    ld_ms = '0; ld_tv = '0; ld_epc = '0; ld_cause = '0;
    bus.trap_cause = '0; bus.trap_pc = '0; bus.irq_pc = '0;
    clear_reqs();
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;
    @(negedge clk);

    // ecall, direct mtvec
    setup(64'h1808, 64'h8000_1000, 64'h0);
    run_seq(0, 64'd11, 64'h8000_0010, 1'b0, 1'b0);
    chk("ecall_ms",  csr_ms, 64'h1880);
    chk("ecall_rpc", last_rpc, 64'h8000_1000);

    // vectored interrupt
    setup(m_ms, 64'h8000_1001, m_epc);
    run_seq(2, 64'd0, 64'h8000_0200, 1'b0, 1'b0);
    chk("virq_rpc",   last_rpc, 64'h8000_101C);
    chk("virq_cause", csr_cause, 64'h8000_0000_0000_0007);
    chk("virq_epc",   csr_epc, 64'h8000_0200);

    // vectored mode, exception goes to base
    run_seq(0, 64'd2, 64'h8000_0300, 1'b0, 1'b0);
    chk("vexc_rpc", last_rpc, 64'h8000_1000);

    // mret
    setup(64'h1880, 64'h8000_1000, 64'h8000_0014);
    run_seq(1, 64'd0, 64'd0, 1'b0, 1'b0);
    chk("mret_ms",  csr_ms, 64'h1888);
    chk("mret_rpc", last_rpc, 64'h8000_0014);

    // all requests at once plus requests raised while busy
    run_seq(0, 64'd5, 64'h8000_0400, 1'b1, 1'b1);
    chk("arb_cause", csr_cause, 64'd5);

    // interrupt gated by irq_en / irq_window
    for (int g = 0; g < 2; g++) begin
      bus.irq_pending = 1'b1; bus.irq_en = (g == 1); bus.irq_window = (g == 0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("irq_gate_busy", 64'(bus.busy), 64'd0);
      end
      clear_reqs();
    end

    // reset in the middle of a trap
    setup(64'h8, 64'h8000_2000, 64'h0);
    bus.trap_req = 1'b1; bus.trap_cause = 64'd11; bus.trap_pc = 64'h8000_0501;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) clear_reqs();
    end
    rst = 1'b0;
    #1 chk_quiet("midrst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_rv", 64'(bus.redirect_valid), 64'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    m_epc = 64'h8000_0501; m_cause = 64'd11;
    chk("midrst_ms", csr_ms, 64'h8);
    run_seq(1, 64'd0, 64'd0, 1'b0, 1'b0);
    chk("midrst_mret_rpc", last_rpc, 64'h8000_0500);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      pc0 = r64(); c0 = r64();
      if ($urandom_range(0, 1) == 1) setup(r64(), r64(), r64());
      run_seq(kind, c0, pc0, kind == 0 && $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
